// File: rtl/regfile_wb_arbiter_if.sv
// Write-port bus of the register-file write-back arbiter: pipeline write, secondary
// valid/ready producer, regfile write port, forwarding lookup and FIFO occupancy.
interface regfile_wb_arbiter_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          p_we;
    logic [4:0]    p_waddr;
    logic [31:0]   p_wdata;
    logic          s_valid;
    logic          s_ready;
    logic [4:0]    s_waddr;
    logic [31:0]   s_wdata;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata;
    logic [4:0]    fwd_raddr;
    logic          fwd_hit;
    logic [31:0]   fwd_data;
    logic [CW-1:0] pending;

    modport master (
        output p_we, p_waddr, p_wdata, s_valid, s_waddr, s_wdata, fwd_raddr,
        input  s_ready, rf_we, rf_waddr, rf_wdata, fwd_hit, fwd_data, pending
    );

    modport slave (
        input  p_we, p_waddr, p_wdata, s_valid, s_waddr, s_wdata, fwd_raddr,
        output s_ready, rf_we, rf_waddr, rf_wdata, fwd_hit, fwd_data, pending
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Owns the regfile write port: pipeline writes win (1 cycle), secondary results queue in a
// DEPTH-entry FIFO (>=1 cycle); s_ready drops only when the FIFO is full.
module regfile_wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } ent_t;

    ent_t             mem_q [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_waddr_q, rf_waddr_d;
    logic [31:0]      rf_wdata_q, rf_wdata_d;
    logic             p_act, push, pop;
    logic [AW-1:0]    fwd_idx;
    logic             fwd_hit;
    logic [31:0]      fwd_data;

    assign p_act       = bus.p_we && (bus.p_waddr != 5'd0);
    assign bus.s_ready = !rst && (count_q < CW'(DEPTH));
    // Writes to r0 complete the handshake but never occupy a slot.
    assign push        = bus.s_valid && bus.s_ready && (bus.s_waddr != 5'd0);
    assign pop         = !p_act && (count_q != '0);

    always_comb begin
        live_d     = live_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (p_act) begin
            // A pipeline write makes every older queued result for that register stale.
            for (int i = 0; i < DEPTH; i++) begin
                if (mem_q[i].waddr == bus.p_waddr) begin
                    live_d[i] = 1'b0;
                end
            end
            rf_we_d    = 1'b1;
            rf_waddr_d = bus.p_waddr;
            rf_wdata_d = bus.p_wdata;
        end else if (pop) begin
            rf_we_d         = live_q[head_q];
            rf_waddr_d      = mem_q[head_q].waddr;
            rf_wdata_d      = mem_q[head_q].wdata;
            live_d[head_q]  = 1'b0;
            head_d          = head_q + AW'(1);
        end
        // Applied after the kill so a same-cycle enqueue counts as newer.
        if (push) begin
            live_d[tail_q] = 1'b1;
            tail_d         = tail_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            live_q     <= live_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= '{waddr: bus.s_waddr, wdata: bus.s_wdata};
        end
    end

    // Scan oldest to youngest so the youngest live match is the one left standing.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        if (bus.fwd_raddr != 5'd0) begin
            if (rf_we_q && (rf_waddr_q == bus.fwd_raddr)) begin
                fwd_hit  = 1'b1;
                fwd_data = rf_wdata_q;
            end
            for (int k = 0; k < DEPTH; k++) begin
                fwd_idx = head_q + AW'(k);
                if (live_q[fwd_idx] && (mem_q[fwd_idx].waddr == bus.fwd_raddr)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = mem_q[fwd_idx].wdata;
                end
            end
        end
    end

    assign bus.rf_we    = rf_we_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.fwd_hit  = fwd_hit;
    assign bus.fwd_data = fwd_data;
    assign bus.pending  = count_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: vector table plus scoreboarded write ordering and corner sequences.
module tb_regfile_wb_arbiter;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DEPTH(DEPTH)) bus ();
    regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard of queued secondary writes in accept order.
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        bit          live;
    } sb_t;

    sb_t         sbq[$];
    bit          exp_we = 1'b0;
    logic [4:0]  exp_a  = '0;
    logic [31:0] exp_d  = '0;
    logic [31:0] rf_shadow [32];
    bit          saw_stale = 1'b0;

    initial begin : model
        bit  room;
        sb_t e;
        forever begin
            @(posedge clk);
            if (rst) begin
                sbq.delete();
                exp_we = 1'b0;
            end else begin
                room = sbq.size() < DEPTH;
                if (bus.p_we && bus.p_waddr != 5'd0) begin
                    foreach (sbq[i]) if (sbq[i].a == bus.p_waddr) sbq[i].live = 1'b0;
                    exp_we = 1'b1;
                    exp_a  = bus.p_waddr;
                    exp_d  = bus.p_wdata;
                end else if (sbq.size() != 0) begin
                    e      = sbq.pop_front();
                    exp_we = e.live;
                    exp_a  = e.a;
                    exp_d  = e.d;
                end else begin
                    exp_we = 1'b0;
                end
                if (bus.s_valid && room && bus.s_waddr != 5'd0) begin
                    e.a = bus.s_waddr;
                    e.d = bus.s_wdata;
                    e.live = 1'b1;
                    sbq.push_back(e);
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst) begin
                sbq.delete();
                exp_we = 1'b0;
            end
            chk("mon_we", 32'(bus.rf_we), 32'(exp_we));
            if (exp_we) begin
                chk("mon_waddr", 32'(bus.rf_waddr), 32'(exp_a));
                chk("mon_wdata", bus.rf_wdata, exp_d);
            end
            chk("mon_pending", 32'(bus.pending), 32'(sbq.size()));
            chk("mon_ready", 32'(bus.s_ready), 32'(!rst && sbq.size() < DEPTH));
            if (bus.rf_we) begin
                rf_shadow[bus.rf_waddr] = bus.rf_wdata;
                if (bus.rf_waddr == 5'd7 && bus.rf_wdata == 32'h11) saw_stale = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        p_we;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        sv;
        logic [4:0]  sa;
        logic [31:0] sd;
        logic        e_we;
        logic [4:0]  e_a;
        logic [31:0] e_d;
        logic [2:0]  e_pend;
    } vec_t;

    function automatic vec_t mk(bit pwe, int pa, int pd, bit sv, int sa, int sd,
                                bit ewe, int ea, int ed, int ep);
        vec_t v;
        v.p_we = pwe;  v.pa = 5'(pa);  v.pd = pd;
        v.sv   = sv;   v.sa = 5'(sa);  v.sd = sd;
        v.e_we = ewe;  v.e_a = 5'(ea); v.e_d = ed; v.e_pend = 3'(ep);
        return v;
    endfunction

    task automatic drive(input bit pwe, input int pa, input int pd,
                         input bit sv, input int sa, input int sd);
        bus.p_we    = pwe;
        bus.p_waddr = 5'(pa);
        bus.p_wdata = pd;
        bus.s_valid = sv;
        bus.s_waddr = 5'(sa);
        bus.s_wdata = sd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vt [9];

    initial begin : main
        vt[0] = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,     1, 5, 32'hDEADBEEF, 0);
        vt[1] = mk(1, 0, 32'h1234,     0, 0, 0,     0, 5, 32'hDEADBEEF, 0);
        vt[2] = mk(0, 0, 0,            0, 0, 0,     0, 5, 32'hDEADBEEF, 0);
        vt[3] = mk(0, 0, 0,            1, 9, 32'h99, 0, 5, 32'hDEADBEEF, 1);
        vt[4] = mk(0, 0, 0,            0, 0, 0,     1, 9, 32'h99, 0);
        vt[5] = mk(0, 0, 0,            1, 0, 32'h55, 0, 9, 32'h99, 0);
        vt[6] = mk(1, 1, 32'h100,      1, 2, 32'h200, 1, 1, 32'h100, 1);
        vt[7] = mk(1, 0, 0,            0, 0, 0,     1, 2, 32'h200, 0);
        vt[8] = mk(0, 0, 0,            0, 0, 0,     0, 2, 32'h200, 0);

        for (int i = 0; i < 32; i++) rf_shadow[i] = '0;
        drive(0, 0, 0, 0, 0, 0);
        bus.fwd_raddr = 5'd5;

        // Reset state
        repeat (2) tick();
        chk("rst_we", 32'(bus.rf_we), 0);
        chk("rst_pending", 32'(bus.pending), 0);
        chk("rst_ready", 32'(bus.s_ready), 0);
        chk("rst_fwd_hit", 32'(bus.fwd_hit), 0);
        chk("rst_waddr", 32'(bus.rf_waddr), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(bus.s_ready), 1);
        tick();
        chk("idle_we", 32'(bus.rf_we), 0);
        chk("idle_pending", 32'(bus.pending), 0);

        // Vector table
        for (int i = 0; i < 9; i++) begin
            drive(vt[i].p_we, int'(vt[i].pa), int'(vt[i].pd), vt[i].sv, int'(vt[i].sa), int'(vt[i].sd));
            tick();
            chk($sformatf("vec%0d_we", i), 32'(bus.rf_we), 32'(vt[i].e_we));
            chk($sformatf("vec%0d_waddr", i), 32'(bus.rf_waddr), 32'(vt[i].e_a));
            chk($sformatf("vec%0d_wdata", i), bus.rf_wdata, vt[i].e_d);
            chk($sformatf("vec%0d_pending", i), 32'(bus.pending), 32'(vt[i].e_pend));
            chk($sformatf("vec%0d_ready", i), 32'(bus.s_ready), 1);
        end

        // Backpressure with the primary writing every cycle
        for (int i = 0; i < 4; i++) begin
            drive(1, 16 + i, 32'hB0 + i, 1, 20 + i, 32'hC0 + i);
            chk($sformatf("bp_ready_pre%0d", i), 32'(bus.s_ready), 1);
            tick();
        end
        chk("bp_full_pending", 32'(bus.pending), 4);
        chk("bp_full_ready", 32'(bus.s_ready), 0);
        drive(1, 28, 32'hB4, 1, 24, 32'hCE);
        tick();
        chk("bp_still_full", 32'(bus.pending), 4);
        drive(0, 0, 0, 1, 24, 32'hCE);
        tick();
        chk("bp_first_pop_addr", 32'(bus.rf_waddr), 20);
        chk("bp_first_pop_data", bus.rf_wdata, 32'hC0);
        chk("bp_ready_back", 32'(bus.s_ready), 1);
        chk("bp_pending3", 32'(bus.pending), 3);
        tick();
        chk("bp_second_pop", bus.rf_wdata, 32'hC1);
        chk("bp_pending_after_push_pop", 32'(bus.pending), 3);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk("bp_third_pop", bus.rf_wdata, 32'hC2);
        repeat (3) tick();
        chk("bp_last_pop", bus.rf_wdata, 32'hCE);
        chk("bp_drained", 32'(bus.pending), 0);
        tick();

        // Reset mid-burst with three queued entries
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 32'hA0 + i, 1, 11 + i, 32'hE0 + i);
            tick();
        end
        drive(1, 1, 32'hA3, 0, 0, 0);
        bus.fwd_raddr = 5'd11;
        tick();
        chk("mid_pre_we", 32'(bus.rf_we), 1);
        chk("mid_pre_pending", 32'(bus.pending), 3);
        chk("mid_pre_fwd", 32'(bus.fwd_hit), 1);
        rst = 1'b1;
        #1;
        chk("mid_async_we", 32'(bus.rf_we), 0);
        chk("mid_async_pending", 32'(bus.pending), 0);
        chk("mid_async_ready", 32'(bus.s_ready), 0);
        chk("mid_async_fwd", 32'(bus.fwd_hit), 0);
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (6) tick();
        chk("mid_no_r11", rf_shadow[11], 0);
        chk("mid_no_r12", rf_shadow[12], 0);
        chk("mid_no_r13", rf_shadow[13], 0);

        // Kill of a stale queued result
        drive(0, 0, 0, 1, 7, 32'h11);
        tick();
        drive(1, 7, 32'h22, 1, 7, 32'h33);
        tick();
        chk("kill_prim_data", bus.rf_wdata, 32'h22);
        chk("kill_pending", 32'(bus.pending), 2);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk("kill_slot_we", 32'(bus.rf_we), 0);
        tick();
        chk("kill_new_we", 32'(bus.rf_we), 1);
        chk("kill_new_data", bus.rf_wdata, 32'h33);
        tick();
        chk("kill_final_r7", rf_shadow[7], 32'h33);
        chk("kill_never_stale", 32'(saw_stale), 0);

        // Forwarding priority
        drive(1, 1, 32'h71, 1, 3, 32'h9);
        tick();
        drive(1, 1, 32'h72, 1, 3, 32'hA);
        tick();
        drive(1, 1, 32'h73, 1, 3, 32'hB);
        tick();
        bus.fwd_raddr = 5'd3;
        #1;
        chk("fwd_q_hit", 32'(bus.fwd_hit), 1);
        chk("fwd_q_data", bus.fwd_data, 32'hB);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk("fwd_out9_addr", 32'(bus.rf_waddr), 3);
        chk("fwd_out9_data", bus.rf_wdata, 32'h9);
        chk("fwd_both_data", bus.fwd_data, 32'hB);
        bus.fwd_raddr = 5'd0;
        #1;
        chk("fwd_r0_hit", 32'(bus.fwd_hit), 0);
        chk("fwd_r0_data", bus.fwd_data, 0);
        bus.fwd_raddr = 5'd4;
        #1;
        chk("fwd_miss_hit", 32'(bus.fwd_hit), 0);
        bus.fwd_raddr = 5'd3;
        tick();
        chk("fwd_oneleft_data", bus.fwd_data, 32'hB);
        tick();
        chk("fwd_outB_pending", 32'(bus.pending), 0);
        chk("fwd_outB_hit", 32'(bus.fwd_hit), 1);
        chk("fwd_outB_data", bus.fwd_data, 32'hB);
        tick();
        chk("fwd_gone_hit", 32'(bus.fwd_hit), 0);
        chk("fwd_gone_data", bus.fwd_data, 0);

        // Pointer wrap: one accept and one pop per cycle
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 1, (i % 2) ? 13 : 12, 32'h1000 + i);
            tick();
            chk($sformatf("wrap_pending%0d", i), 32'(bus.pending), 1);
            if (i > 0) chk($sformatf("wrap_data%0d", i), bus.rf_wdata, 32'h1000 + i - 1);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk("wrap_last_data", bus.rf_wdata, 32'h1009);
        chk("wrap_drained", 32'(bus.pending), 0);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter that owns the single write port (we/waddr/wdata) of the 32×32 register file. It merges two producers: the in-order pipeline write-back, which always wins and never stalls, and a long-latency producer (mul/div, load-miss return) that is buffered in a DEPTH-entry FIFO with a valid/ready handshake. It guarantees that a queued stale result never overwrites a newer pipeline result. It also provides a forwarding lookup so readers can see values not yet committed to the register file.

## Interface
- DEPTH, 4: secondary FIFO entries; power of two, 2..16.
- clk  in  1  system clock; outputs update on posedge, so the regfile samples them at the following negedge.
- rst  in  1  reset, asynchronous, active-high.
- p_we  in  1  primary (pipeline) write request; no backpressure.
- p_waddr  in  5  primary destination register.
- p_wdata  in  32  primary data.
- s_valid  in  1  secondary request valid.
- s_ready  out  1  secondary request accepted when s_valid && s_ready at posedge.
- s_waddr  in  5  secondary destination register.
- s_wdata  in  32  secondary data.
- rf_we  out  1  to regfile we.
- rf_waddr  out  5  to regfile waddr.
- rf_wdata  out  32  to regfile wdata.
- fwd_raddr  in  5  forwarding lookup address.
- fwd_hit  out  1  a pending or in-flight value exists for fwd_raddr.
- fwd_data  out  32  newest such value; 0 when fwd_hit=0.
- pending  out  clog2(DEPTH)+1  live+killed FIFO occupancy.

## Operation
- FIFO: DEPTH entries of {waddr, wdata, live}, with head/tail pointers that wrap modulo DEPTH and an occupancy count.
- Enqueue: on s_valid && s_ready. s_waddr=0 completes the handshake but is discarded (not enqueued).
- s_ready = !rst && count < DEPTH, taken from the current count. A pop in the same cycle does not allow a push into a full FIFO.
- Kill: when p_we && p_waddr≠0, every FIFO entry currently stored with waddr==p_waddr gets live=0. An entry enqueued in that same cycle is considered newer and is not killed.
- Output selection each posedge, in priority order:
  1. p_we && p_waddr≠0: rf_we=1, rf_waddr=p_waddr, rf_wdata=p_wdata.
  2. Else, if the FIFO is non-empty: pop the head. rf_we=head.live, with head's addr/data.
  3. Otherwise rf_we=0, and rf_waddr/rf_wdata hold their previous values.
- Primary p_waddr=0 is treated as idle, so the FIFO may pop in that cycle.
- Killed entries consume one pop slot with rf_we=0 and are never written.
- Forwarding is combinational:
  - If fwd_raddr=0, then fwd_hit=0.
  - Otherwise, the youngest live FIFO entry matching fwd_raddr wins.
  - Else, if rf_we && rf_waddr==fwd_raddr, return rf_wdata.
  - Else fwd_hit=0.
- Consistency rule: the value the regfile finally holds for any address equals the last write in program order, where primary writes are ordered at their cycle and secondary writes at their accept cycle.

## Timing
- Reset (async, immediate):
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - FIFO emptied: count=0, pointers=0, all live=0.
  - pending=0, s_ready=0 while rst is high, fwd_hit=0.
  - Reset mid-operation drops all queued results; rf_we deasserts without waiting for a clock.
- Primary latency: 1 cycle, registered at posedge N and committed to the regfile at negedge N.
- Secondary latency: at least 1 cycle after accept. With an empty FIFO and no primary write in the next cycle, an entry accepted at posedge N appears on rf_* after posedge N+1.
- Throughput: one regfile write per cycle. The secondary starves only while primary writes every cycle. s_ready stays high while count<DEPTH.
- Wrap-around: pointers wrap with no bubble. Push and pop in the same cycle leave count unchanged.

## Test plan
- Reset then idle: rf_we=0, pending=0, s_ready=1 after rst falls. Assert rst mid-burst with 3 entries queued: rf_we drops asynchronously, pending=0, and no queued value is ever written.
- Primary only: p_we with addr 5, data 0xDEADBEEF at cycle N gives rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF after posedge N. A write to addr 0 gives rf_we=0.
- Secondary backpressure with DEPTH=4 and primary writing every cycle:
  - 4 accepts, then s_ready=0 and pending=4.
  - Drop the primary: entries drain in FIFO order, one per cycle, and s_ready returns after the first pop.
- Kill:
  - Enqueue (addr 7, 0x11).
  - Primary writes (addr 7, 0x22) in the same cycle as enqueue (addr 7, 0x33).
  - Final regfile r7=0x33; 0x11 is never driven with rf_we=1.
- Forwarding:
  - FIFO holds (3, 0xA) then (3, 0xB), and the output register holds (3, 0x9).
  - fwd_raddr=3 gives hit=1, data=0xB. After both entries drain, data=0xB from the output register, then hit=0. fwd_raddr=0 gives hit=0.
- Pointer wrap: 10 accept/pop pairs with DEPTH=4 and alternating addresses. The write sequence on rf_* matches the accept order exactly, with pending≤1 throughout.
